// File: rtl/scan_op_controller.sv
// scan_op_controller: issues one seqOp per host command to the SequencerGroup array of a DRAM
// row, waits out the array pipeline, samples compare / insert-point / row-full and returns one
// response per command. One command is in flight at a time.
// Optional build macro SCAN_OP_CTRL_ONEHOT_CHK_EN: flags a multi-hot insPtVec or an {eq,lt}=11
// compare on rspErr. Without it rspErr is tied 0.
module scan_op_controller #(
    parameter int unsigned NUM_GROUPS = 32,
    parameter int unsigned SCAN_LAT   = 3,   // issue cycle to sample cycle, minimum 2
    parameter int unsigned GRP_BITS   = $clog2(NUM_GROUPS),
    parameter int unsigned TGT_BITS   = 16,
    parameter int unsigned OP_BITS    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic [1:0]            cmdKind,
    input  logic                  cmdRowInx,
    input  logic [TGT_BITS-1:0]   cmdTarget,
    output logic [OP_BITS-1:0]    seqOp,
    output logic [TGT_BITS-1:0]   target,
    output logic                  rowType,
    input  logic [1:0]            grpRslt,    // {eq, lt}
    input  logic [NUM_GROUPS-1:0] insPtVec,
    input  logic [NUM_GROUPS-1:0] rowFullVec,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic                  rspEq,
    output logic                  rspLt,
    output logic [GRP_BITS-1:0]   rspInsGrp,
    output logic                  rspInsHit,
    output logic                  rspRowFull,
    output logic                  rspErr
);

    localparam logic [OP_BITS-1:0] OP_NOOP  = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_CFG_C = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_CFG_G = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_SCAN  = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] OP_SCIN  = OP_BITS'(4);

    localparam int unsigned CNT_BITS = $clog2(SCAN_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StSample,
        StResp
    } state_e;

    state_e              state;
    logic [1:0]          kindQ;
    logic [CNT_BITS-1:0] waitCnt;

    logic [GRP_BITS-1:0] insGrpC;
    logic                insHitC;

    function automatic logic [OP_BITS-1:0] opMap(input logic [1:0] kind);
        case (kind)
            2'd0:    opMap = OP_CFG_C;
            2'd1:    opMap = OP_CFG_G;
            2'd2:    opMap = OP_SCAN;
            default: opMap = OP_SCIN;
        endcase
    endfunction

    // Lowest set insert-point wins; scanning downwards lets lower indices overwrite higher ones.
    always_comb begin
        insGrpC = '0;
        insHitC = 1'b0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (insPtVec[i]) begin
                insGrpC = GRP_BITS'(i);
                insHitC = 1'b1;
            end
        end
    end

    // Command sequencer: accept, issue one opcode cycle, wait the pipeline, sample, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            kindQ      <= 2'd0;
            waitCnt    <= '0;
            cmdReady   <= 1'b1;
            seqOp      <= OP_NOOP;
            target     <= '0;
            rowType    <= 1'b0;
            rspValid   <= 1'b0;
            rspEq      <= 1'b0;
            rspLt      <= 1'b0;
            rspInsGrp  <= '0;
            rspInsHit  <= 1'b0;
            rspRowFull <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (cmdValid && cmdReady) begin
                        kindQ    <= cmdKind;
                        rowType  <= cmdRowInx;
                        target   <= cmdTarget;
                        seqOp    <= opMap(cmdKind);
                        cmdReady <= 1'b0;
                        state    <= StIssue;
                    end
                end
                StIssue: begin
                    seqOp <= OP_NOOP;
                    if (!kindQ[1]) begin
                        // Config commands are acknowledged with all-zero fields.
                        rspValid <= 1'b1;
                        state    <= StResp;
                    end else begin
                        waitCnt <= CNT_BITS'(SCAN_LAT - 1);
                        state   <= StWait;
                    end
                end
                StWait: begin
                    waitCnt <= waitCnt - CNT_BITS'(1);
                    if (waitCnt == CNT_BITS'(1)) begin
                        state <= StSample;
                    end
                end
                StSample: begin
                    rspEq      <= grpRslt[1];
                    rspLt      <= grpRslt[0];
                    rspInsGrp  <= insGrpC;
                    rspInsHit  <= insHitC;
                    rspRowFull <= |rowFullVec;
                    rspValid   <= 1'b1;
                    state      <= StResp;
                end
                StResp: begin
                    if (rspReady) begin
                        rspValid   <= 1'b0;
                        rspEq      <= 1'b0;
                        rspLt      <= 1'b0;
                        rspInsGrp  <= '0;
                        rspInsHit  <= 1'b0;
                        rspRowFull <= 1'b0;
                        cmdReady   <= 1'b1;
                        state      <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef SCAN_OP_CTRL_ONEHOT_CHK_EN
    logic errC;

    // Multi-hot insert points or eq&&lt together indicate a broken group chain.
    always_comb begin
        errC = ((insPtVec & (insPtVec - NUM_GROUPS'(1))) != '0) || (grpRslt == 2'b11);
    end

    // Error flag follows the same sample/handshake timing as the other response fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rspErr <= 1'b0;
        end else if (state == StSample) begin
            rspErr <= errC;
        end else if (state == StResp && rspReady) begin
            rspErr <= 1'b0;
        end
    end
`else
    assign rspErr = 1'b0;
`endif

endmodule

// File: tb/tb_scan_op_controller.sv
// Self-checking bench for scan_op_controller: directed corner cases, randomized commands and
// asynchronous reset at several points of a transaction, checked against a behavioural model.
module tb_scan_op_controller;

    localparam int unsigned NUM_GROUPS = 32;
    localparam int unsigned SCAN_LAT   = 3;
    localparam int unsigned GRP_BITS   = 5;
    localparam int unsigned TGT_BITS   = 16;
    localparam int unsigned OP_BITS    = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmdValid;
    logic                  cmdReady;
    logic [1:0]            cmdKind;
    logic                  cmdRowInx;
    logic [TGT_BITS-1:0]   cmdTarget;
    logic [OP_BITS-1:0]    seqOp;
    logic [TGT_BITS-1:0]   target;
    logic                  rowType;
    logic [1:0]            grpRslt;
    logic [NUM_GROUPS-1:0] insPtVec;
    logic [NUM_GROUPS-1:0] rowFullVec;
    logic                  rspValid;
    logic                  rspReady;
    logic                  rspEq;
    logic                  rspLt;
    logic [GRP_BITS-1:0]   rspInsGrp;
    logic                  rspInsHit;
    logic                  rspRowFull;
    logic                  rspErr;

    int nTests = 0;
    int nFail  = 0;

    scan_op_controller #(
        .NUM_GROUPS(NUM_GROUPS),
        .SCAN_LAT  (SCAN_LAT),
        .GRP_BITS  (GRP_BITS),
        .TGT_BITS  (TGT_BITS),
        .OP_BITS   (OP_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdKind   (cmdKind),
        .cmdRowInx (cmdRowInx),
        .cmdTarget (cmdTarget),
        .seqOp     (seqOp),
        .target    (target),
        .rowType   (rowType),
        .grpRslt   (grpRslt),
        .insPtVec  (insPtVec),
        .rowFullVec(rowFullVec),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .rspEq     (rspEq),
        .rspLt     (rspLt),
        .rspInsGrp (rspInsGrp),
        .rspInsHit (rspInsHit),
        .rspRowFull(rspRowFull),
        .rspErr    (rspErr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference response for one command, from the rules rather than any state machine.
    task automatic model(input logic [1:0] kind, input logic [1:0] grp, input logic [31:0] ins,
                         input logic [31:0] rf, output logic [4:0] eGrp, output logic eHit,
                         output logic eFull, output logic eErr, output logic eEq,
                         output logic eLt);
        logic [31:0] lowBit;
        lowBit = ins & (~ins + 32'd1);
        if (kind < 2'd2) begin
            {eGrp, eHit, eFull, eErr, eEq, eLt} = '0;
        end else begin
            eEq   = grp[1];
            eLt   = grp[0];
            eHit  = (ins != 0);
            eGrp  = (ins == 0) ? 5'd0 : 5'($clog2(lowBit));
            eFull = (rf != 0);
`ifdef SCAN_OP_CTRL_ONEHOT_CHK_EN
            eErr  = ($countones(ins) > 1) || (grp == 2'b11);
`else
            eErr  = 1'b0;
`endif
        end
    endtask

    task automatic chkRsp(input string tag, input logic [4:0] eGrp, input logic eHit,
                          input logic eFull, input logic eErr, input logic eEq, input logic eLt);
        chk({tag, ".rspValid"}, rspValid, 1);
        chk({tag, ".rspEq"}, rspEq, eEq);
        chk({tag, ".rspLt"}, rspLt, eLt);
        chk({tag, ".rspInsGrp"}, rspInsGrp, eGrp);
        chk({tag, ".rspInsHit"}, rspInsHit, eHit);
        chk({tag, ".rspRowFull"}, rspRowFull, eFull);
        chk({tag, ".rspErr"}, rspErr, eErr);
        chk({tag, ".cmdReady"}, cmdReady, 0);
    endtask

    // One full command: real array inputs only in the sample cycle, garbage elsewhere.
    task automatic runCmd(input string tag, input logic [1:0] kind, input logic rowInx,
                          input logic [15:0] tgt, input logic [1:0] grp, input logic [31:0] ins,
                          input logic [31:0] rf, input int stall);
        int respCyc;
        logic [2:0] expOp;
        logic [4:0] eGrp;
        logic eHit, eFull, eErr, eEq, eLt;
        model(kind, grp, ins, rf, eGrp, eHit, eFull, eErr, eEq, eLt);
        respCyc = (kind < 2'd2) ? 2 : int'(SCAN_LAT) + 2;
        expOp   = 3'(kind) + 3'd1;
        @(negedge clk);
        chk({tag, ".cmdReadyIdle"}, cmdReady, 1);
        cmdValid  = 1'b1;
        cmdKind   = kind;
        cmdRowInx = rowInx;
        cmdTarget = tgt;
        @(posedge clk);
        for (int c = 1; c < respCyc; c++) begin
            @(negedge clk);
            cmdValid  = 1'b0;
            cmdKind   = 2'($urandom);
            cmdTarget = 16'($urandom);
            cmdRowInx = 1'($urandom);
            chk({tag, ".seqOp"}, seqOp, (c == 1) ? expOp : 3'd0);
            chk({tag, ".rspValidEarly"}, rspValid, 0);
            chk({tag, ".cmdReadyBusy"}, cmdReady, 0);
            chk({tag, ".target"}, target, tgt);
            if (c == 1) chk({tag, ".rowType"}, rowType, rowInx);
            if (c == int'(SCAN_LAT) + 1) begin
                grpRslt = grp; insPtVec = ins; rowFullVec = rf;
            end else begin
                grpRslt = 2'($urandom); insPtVec = $urandom; rowFullVec = $urandom;
            end
            @(posedge clk);
        end
        @(negedge clk);
        chkRsp(tag, eGrp, eHit, eFull, eErr, eEq, eLt);
        chk({tag, ".seqOpResp"}, seqOp, 0);
        for (int s = 0; s < stall; s++) begin
            rspReady = 1'b0;
            cmdValid = 1'b1;
            cmdKind  = 2'($urandom);
            grpRslt = 2'($urandom); insPtVec = $urandom; rowFullVec = $urandom;
            @(posedge clk);
            @(negedge clk);
            chkRsp({tag, ".stall"}, eGrp, eHit, eFull, eErr, eEq, eLt);
        end
        rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".rspValidAfter"}, rspValid, 0);
        chk({tag, ".cmdReadyAfter"}, cmdReady, 1);
        chk({tag, ".noEarlyAccept"}, seqOp, 0);
        rspReady = 1'b0;
        cmdValid = 1'b0;
    endtask

    // Accept a command, then assert reset asynchronously in cycle cyc after the accept.
    task automatic resetAfter(input string tag, input logic [1:0] kind, input int cyc);
        @(negedge clk);
        cmdValid  = 1'b1;
        cmdKind   = kind;
        cmdRowInx = 1'b1;
        cmdTarget = 16'hBEEF;
        grpRslt = 2'b10; insPtVec = '1; rowFullVec = '1;
        @(posedge clk);
        #1 cmdValid = 1'b0;
        repeat (cyc - 1) @(posedge clk);
        @(negedge clk);
        if (cyc == 1) chk({tag, ".preSeqOp"}, seqOp, 3'(kind) + 3'd1);
        #1 reset = 1'b1;
        #1;
        chk({tag, ".seqOp"}, seqOp, 0);
        chk({tag, ".rspValid"}, rspValid, 0);
        chk({tag, ".cmdReady"}, cmdReady, 1);
        chk({tag, ".target"}, target, 0);
        chk({tag, ".rspInsHit"}, rspInsHit, 0);
        chk({tag, ".rspRowFull"}, rspRowFull, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmdValid = 1'b0; cmdKind = 2'd0; cmdRowInx = 1'b0; cmdTarget = '0;
        grpRslt = 2'b00; insPtVec = '0; rowFullVec = '0; rspReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.cmdReady", cmdReady, 1);
        chk("reset.seqOp", seqOp, 0);
        chk("reset.target", target, 0);
        chk("reset.rspValid", rspValid, 0);
        chk("reset.rspEq", rspEq, 0);
        chk("reset.rspInsGrp", rspInsGrp, 0);
        chk("reset.rspErr", rspErr, 0);
        reset = 1'b0;

        runCmd("scanEq", 2'd2, 1'b1, 16'h1234, 2'b10, 32'h0, 32'h0, 0);
        runCmd("scinIns", 2'd3, 1'b0, 16'h00A5, 2'b01, 32'h0000_0110, 32'h8000_0000, 0);
        runCmd("cfgG", 2'd1, 1'b1, 16'h5555, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        runCmd("cfgC", 2'd0, 1'b0, 16'hAAAA, 2'b10, 32'h1, 32'h1, 1);
        runCmd("stall10", 2'd2, 1'b0, 16'h0F0F, 2'b01, 32'h0000_8000, 32'h0000_0001, 10);
        runCmd("topBit", 2'd3, 1'b1, 16'hFFFF, 2'b00, 32'h8000_0000, 32'h0, 0);
        runCmd("multiHot", 2'd2, 1'b0, 16'h0003, 2'b01, 32'h0000_0003, 32'h0, 0);
        runCmd("eqLt", 2'd3, 1'b0, 16'h0C0C, 2'b11, 32'h0000_0040, 32'h0, 2);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins;
            case ($urandom_range(0, 3))
                0:       ins = 32'h0;
                1:       ins = 32'h1 << $urandom_range(0, 31);
                2:       ins = 32'h8000_0000;
                default: ins = $urandom;
            endcase
            runCmd("rand", 2'($urandom), 1'($urandom), 16'($urandom), 2'($urandom), ins,
                   ($urandom_range(0, 1) == 1) ? $urandom : 32'h0, $urandom_range(0, 3));
        end

        resetAfter("rstIssue", 2'd2, 1);
        resetAfter("rstWait", 2'd3, 2);
        resetAfter("rstResp", 2'd2, int'(SCAN_LAT) + 2);
        runCmd("postReset", 2'd2, 1'b1, 16'h7777, 2'b10, 32'h0000_0004, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
